// File: rtl/noc_packet_transmitter_if.sv
`default_nettype none
// ============================================================================
// Module      : noc_packet_transmitter_if
// Description : Producer-side and link-side valid/ready bundle plus status
//               outputs of the NoC packet transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
interface noc_packet_transmitter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;
    logic                  busy;
    logic [7:0]            pkt_count;

    // master: the environment driving flits in and consuming them at the link
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy, pkt_count
    );

    // slave: the transmitter itself
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, busy, pkt_count
    );
endinterface
`default_nettype wire

// File: rtl/noc_packet_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : noc_packet_transmitter
// Description : Buffers producer flits in a FIFO and releases them to the NoC
//               link as whole PKT_LEN packets over valid/ready, tagging the
//               last flit and counting completed packets.
// Revision    : 1.0 - initial release
// ============================================================================
module noc_packet_transmitter #(
    parameter int DATA_WIDTH = 32,
    parameter int PKT_LEN    = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  wire                          clk,
    input  wire                          reset,
    noc_packet_transmitter_if.slave      bus
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    localparam logic [c_CNT_W-1:0] c_DEPTH    = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0] c_PKT_LEN  = c_CNT_W'(PKT_LEN);
    localparam logic [c_CNT_W-1:0] c_LAST_IDX = c_CNT_W'(PKT_LEN - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]    r_count;
    logic [c_CNT_W-1:0]    r_flit_cnt;
    logic [7:0]            r_pkt_count;
    state_t                r_state;

    state_t                w_state_nxt;
    logic                  w_in_ready;
    logic                  w_out_valid;
    logic                  w_out_last;
    logic                  w_busy;
    logic                  w_flit_clr;
    logic                  w_push;
    logic                  w_pop;

    // in_ready looks only at the registered occupancy, so a full FIFO stays
    // closed for the cycle in which it is being popped.
    assign w_in_ready = (r_count < c_DEPTH);
    assign w_push     = bus.in_valid && w_in_ready;
    assign w_pop      = w_out_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_out_valid = 1'b0;
        w_out_last  = 1'b0;
        w_busy      = 1'b0;
        w_flit_clr  = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A packet only starts once every flit is already buffered,
                // so out_valid can never drop in the middle of a packet.
                if (r_count >= c_PKT_LEN) begin
                    w_state_nxt = S_SEND;
                    w_flit_clr  = 1'b1;
                end
            end
            S_SEND: begin
                w_out_valid = 1'b1;
                w_busy      = 1'b1;
                w_out_last  = (r_flit_cnt == c_LAST_IDX);
                if (w_pop && w_out_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_flit_cnt  <= '0;
            r_pkt_count <= '0;
        end else begin
            if (w_flit_clr) begin
                r_flit_cnt <= '0;
            end else if (w_pop) begin
                r_flit_cnt <= r_flit_cnt + c_CNT_ONE;
            end
            if (w_pop && w_out_last) begin
                r_pkt_count <= r_pkt_count + 8'd1;
            end
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.in_data;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = r_mem[r_rd_ptr];
    assign bus.out_last  = w_out_last;
    assign bus.busy      = w_busy;
    assign bus.pkt_count = r_pkt_count;

endmodule
`default_nettype wire

// File: tb/tb_noc_packet_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : tb_noc_packet_transmitter
// Description : Directed self-checking bench for noc_packet_transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_noc_packet_transmitter;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    noc_packet_transmitter_if #(.DATA_WIDTH(32)) bus ();

    noc_packet_transmitter #(
        .DATA_WIDTH (32),
        .PKT_LEN    (4),
        .FIFO_DEPTH (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        clk           = 1'b0;
        reset         = 1'b1;
        total         = 0;
        bad           = 0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();

        // Reset state, then quiet for 10 cycles
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_last", 32'(bus.out_last), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_pkt_count", 32'(bus.pkt_count), 32'd0);
        for (int i = 0; i < 10; i++) begin
            check("idle_out_valid", 32'(bus.out_valid), 32'd0);
            check("idle_in_ready", 32'(bus.in_ready), 32'd1);
            step();
        end

        // Single packet, out_ready high: valid in cycles 5..8
        bus.out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            bus.in_valid = (i < 4);
            bus.in_data  = 32'h0000_00A0 + 32'(i);
            check("pkt1_valid", 32'(bus.out_valid), 32'((i >= 5) && (i <= 8)));
            check("pkt1_busy", 32'(bus.busy), 32'((i >= 5) && (i <= 8)));
            if (i >= 5) begin
                check("pkt1_data", bus.out_data, 32'h0000_00A0 + 32'(i - 5));
                check("pkt1_last", 32'(bus.out_last), 32'(i == 8));
            end
            step();
        end
        bus.in_valid = 1'b0;
        check("pkt1_bubble", 32'(bus.out_valid), 32'd0);
        check("pkt1_count", 32'(bus.pkt_count), 32'd1);

        // Backpressure: out_ready low in cycles 5..7, B0 held
        for (int i = 0; i < 12; i++) begin
            bus.in_valid  = (i < 4);
            bus.in_data   = 32'h0000_00B0 + 32'(i);
            bus.out_ready = !((i >= 5) && (i <= 7));
            check("bp_valid", 32'(bus.out_valid), 32'(i >= 5));
            if (i >= 5) begin
                check("bp_data", bus.out_data,
                      (i <= 8) ? 32'h0000_00B0 : 32'h0000_00B0 + 32'(i - 8));
                check("bp_last", 32'(bus.out_last), 32'(i == 11));
            end
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check("bp_bubble", 32'(bus.out_valid), 32'd0);
        check("bp_count", 32'(bus.pkt_count), 32'd2);

        // Partial packet: three flits never start a transfer
        for (int i = 0; i < 13; i++) begin
            bus.in_valid = (i < 3);
            bus.in_data  = 32'h0000_00C0 + 32'(i);
            check("part_hold", 32'(bus.out_valid), 32'd0);
            step();
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h0000_00C3;
        step();
        bus.in_valid = 1'b0;
        check("part_lat1", 32'(bus.out_valid), 32'd0);
        step();
        for (int i = 0; i < 4; i++) begin
            check("part_valid", 32'(bus.out_valid), 32'd1);
            check("part_data", bus.out_data, 32'h0000_00C0 + 32'(i));
            check("part_last", 32'(bus.out_last), 32'(i == 3));
            step();
        end
        check("part_bubble", 32'(bus.out_valid), 32'd0);
        check("part_count", 32'(bus.pkt_count), 32'd3);

        // Full FIFO: 8 flits with out_ready low, extra offer refused
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 32'h0000_00D0 + 32'(i);
            check("full_fill_rdy", 32'(bus.in_ready), 32'd1);
            step();
        end
        bus.in_data = 32'h0000_00EE;
        check("full_rdy_low", 32'(bus.in_ready), 32'd0);
        check("full_stall_data", bus.out_data, 32'h0000_00D0);
        step();
        bus.out_ready = 1'b1;
        check("full_rdy_pop_cycle", 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < 9; i++) begin
            if (i == 1) begin
                bus.in_valid = 1'b0;
                check("full_rdy_back", 32'(bus.in_ready), 32'd1);
            end
            check("full_valid", 32'(bus.out_valid), 32'(i != 4));
            if (i != 4) begin
                check("full_data", bus.out_data,
                      32'h0000_00D0 + 32'((i < 4) ? i : i - 1));
                check("full_last", 32'(bus.out_last), 32'((i == 3) || (i == 8)));
            end
            step();
        end
        check("full_end_valid", 32'(bus.out_valid), 32'd0);
        check("full_count", 32'(bus.pkt_count), 32'd5);
        check("full_end_occ", 32'(dut.r_count), 32'd0);

        // Reset mid-packet after the second flit is accepted
        for (int i = 0; i < 7; i++) begin
            bus.in_valid = (i < 4);
            bus.in_data  = 32'h0000_00E0 + 32'(i);
            step();
        end
        check("mid_pre_data", bus.out_data, 32'h0000_00E2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_valid", 32'(bus.out_valid), 32'd0);
        check("mid_busy", 32'(bus.busy), 32'd0);
        check("mid_occ", 32'(dut.r_count), 32'd0);
        check("mid_pkt_count", 32'(bus.pkt_count), 32'd0);
        check("mid_in_ready", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < 9; i++) begin
            bus.in_valid = (i < 4);
            bus.in_data  = 32'h0000_00F0 + 32'(i);
            check("post_valid", 32'(bus.out_valid), 32'((i >= 5) && (i <= 8)));
            if (i >= 5) begin
                check("post_data", bus.out_data, 32'h0000_00F0 + 32'(i - 5));
                check("post_last", 32'(bus.out_last), 32'(i == 8));
            end
            step();
        end
        bus.in_valid = 1'b0;
        check("post_count", 32'(bus.pkt_count), 32'd1);
        check("post_bubble", 32'(bus.out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
